qtable_dump_reader: RTL and testbench
=====================================

Name: qtable_dump_reader

Overview:
- Read-side counterpart to the action-RAM write path. On command, scans Q-table states 0..NUM_STATES-1 and reads all four action RAMs per state.
- Streams every Q value, plus one greedy-policy beat per state, to the host/debug port over a valid/ready handshake.
- Holds the control unit off Q updates for the whole scan so the dump is a consistent snapshot.

Parameters:
- NUM_STATES, 100, number of states scanned; legal range 1..256.
- ADDR_W, 8, action-RAM address width.
- DATA_W, 16, signed Q-value width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle scan request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- freeze  out  1  equals busy; the CU blocks RAM writes (WR_EN low) while it is high.
- done  out  1  one-cycle pulse after the final handshake.
- rd_addr  out  ADDR_W  shared read address driven to all four action RAMs.
- q0_in, q1_in, q2_in, q3_in  in  DATA_W each  signed combinational RAM read data for actions 0..3.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  Q value on a Q beat; max Q on a policy beat.
- out_state  out  ADDR_W  state index of the beat.
- out_act  out  2  action index on a Q beat; greedy action on a policy beat.
- out_kind  out  1  0 = Q beat, 1 = policy beat.
- out_last  out  1  high on the final beat of the scan (policy beat of state NUM_STATES-1).

Behaviour:
- Reset values: busy, freeze, done, out_valid, out_kind and out_last = 0; rd_addr, out_data, out_state and out_act = 0; FSM = IDLE; snapshot registers = 0.
- FSM states: IDLE, LOAD, EMIT, FIN.
- IDLE:
  - start=1 → LOAD, state counter = 0, busy=1 next cycle.
  - start=0 → stay in IDLE.
- LOAD (one cycle):
  - rd_addr = state counter.
  - At the clock edge, capture q0..q3 into snapshot registers.
  - Capture the argmax result and max value.
  - Go to EMIT with beat index = 0.
- EMIT:
  - out_valid=1.
  - Beats 0..3: Q beats, out_act = beat index, out_data = snapshot[beat index].
  - Beat 4: policy beat, out_kind=1.
  - Handshake occurs when out_valid and out_ready are both 1 at the edge. On handshake the beat index advances.
  - After beat 4 is accepted: if state counter = NUM_STATES-1 → FIN; otherwise increment the counter → LOAD.
  - While out_ready=0, all out_* stay stable and out_valid stays high; no beat is dropped or repeated.
- FIN (one cycle): done=1, busy=0 on the following cycle, then → IDLE.
- Timing:
  - Throughput with out_ready held high: 6 cycles per state (1 LOAD + 5 EMIT).
  - NUM_STATES=100 scan = 600 cycles from the first LOAD to the final handshake.
  - done is asserted in the cycle after the final handshake.
- Argmax rule:
  - Signed comparison.
  - Tie → lowest action index wins, matching greedAction's selection order.
  - Max value is the full-width signed value; no saturation and no arithmetic beyond comparison.
- rd_addr holds its last value outside LOAD; RAM reads have no side effects.
- Boundaries:
  - start while busy is ignored; it does not restart or queue a scan.
  - rst mid-scan: everything returns to reset values the next cycle, no done pulse; a later start rescans from state 0.
  - NUM_STATES=1: exactly 5 beats, out_last on beat 4.
  - out_last is asserted only together with out_valid on the final policy beat.

Decomposition:
- Shared package qlearn_pkg:
  - NUM_ACTIONS=4.
  - Beat-kind constants KIND_Q=0 and KIND_POLICY=1.
  - FSM state encodings.
  - Finish-state constant 99.
- Sub-module qmax4_argmax:
  - Combinational, 4 signed DATA_W inputs.
  - Outputs max value and 2-bit index, lowest index on tie.
  - Reusable later by the greedy policy path.

Test Plan:
- Reset: hold rst 3 cycles with start=1 → all outputs 0, FSM stays IDLE, no beats emitted.
- Full scan, NUM_STATES=100, out_ready=1, RAM row s preloaded with {s, s+1, s+2, s+3}:
  - Exactly 500 beats.
  - State 7 beats are data 7,8,9,10 then a policy beat with act=3, data=10.
  - out_last only on beat 500; done pulses once, 1 cycle after it.
  - Total 600 cycles from the first LOAD.
- Ties and signed compare:
  - State 5 = {-100, 50, 50, 0} → policy beat act=1, data=50.
  - State 6 = {-5, -3, -3, -32768} → act=1, data=-3.
- Backpressure: drop out_ready for 3 cycles while state 12 beat 2 is presented → out_data, out_state and out_act stay constant and out_valid stays 1; after release, beat 3 follows with no gaps or duplicates.
- Mid-scan control:
  - Pulse start at beat 37 → ignored; the beat sequence is unchanged.
  - Assert rst at beat 40 → outputs idle next cycle, no done pulse.
  - New start → the first beat is state 0, act 0.
- freeze: high from the cycle after the accepted start through the FIN cycle, then low; confirm it equals busy every cycle.

Source files
------------

// File: rtl/qlearn_pkg.sv
// qlearn_pkg
// Shared constants and types for the Q-learning datapath blocks.
//   NUM_ACTIONS   : number of actions (one action RAM per action)
//   KIND_Q        : out_kind value for a beat carrying one Q value
//   KIND_POLICY   : out_kind value for a beat carrying the greedy action
//   FINISH_STATE  : index of the last state in the default 100-state table
//   LAST_BEAT     : beat index of the per-state policy beat
//   dump_state_t  : FSM encoding used by the Q-table dump reader
package qlearn_pkg;

   localparam int NUM_ACTIONS  = 4;
   localparam int FINISH_STATE = 99;
   localparam int LAST_BEAT    = NUM_ACTIONS;

   localparam logic KIND_Q      = 1'b0;
   localparam logic KIND_POLICY = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2,
      ST_FIN  = 2'd3
   } dump_state_t;

endpackage

// File: rtl/qmax4_argmax.sv
// qmax4_argmax
// Combinational signed maximum and argmax over four Q values.
// Ties resolve to the lowest action index, matching the greedy action
// selection order used elsewhere in the Q-learning core.
// Ports:
//   q0..q3  : signed Q values for actions 0..3
//   max_val : largest of q0..q3 (full width, no saturation)
//   max_idx : index of the first action holding max_val
module qmax4_argmax #(
   parameter int DATA_W = 16
) (
   input  logic signed [DATA_W-1:0] q0,
   input  logic signed [DATA_W-1:0] q1,
   input  logic signed [DATA_W-1:0] q2,
   input  logic signed [DATA_W-1:0] q3,
   output logic signed [DATA_W-1:0] max_val,
   output logic        [1:0]        max_idx
);

   logic signed [DATA_W-1:0] lo_val;
   logic signed [DATA_W-1:0] hi_val;
   logic        [1:0]        lo_idx;
   logic        [1:0]        hi_idx;

   // Two-level tournament. Every comparison is strict greater-than so the
   // lower-indexed contender survives a tie, and the low pair (0/1) beats
   // the high pair (2/3) on an equal maximum.
   always_comb begin
      lo_val  = q0;
      lo_idx  = 2'd0;
      hi_val  = q2;
      hi_idx  = 2'd2;
      if (q1 > q0) begin
         lo_val = q1;
         lo_idx = 2'd1;
      end
      if (q3 > q2) begin
         hi_val = q3;
         hi_idx = 2'd3;
      end
      max_val = lo_val;
      max_idx = lo_idx;
      if (hi_val > lo_val) begin
         max_val = hi_val;
         max_idx = hi_idx;
      end
   end

endmodule

// File: rtl/qtable_dump_reader.sv
// qtable_dump_reader
// Scans Q-table states 0..NUM_STATES-1, reads all four action RAMs for each
// state and streams four Q beats plus one greedy-policy beat per state over
// a valid/ready port. freeze holds the control unit off RAM writes for the
// whole scan so the dump is a consistent snapshot.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : scan request, sampled only while idle
//   busy / freeze      : scan in progress (identical signals)
//   done               : one-cycle pulse after the final beat is accepted
//   rd_addr            : shared read address to the four action RAMs
//   q0_in..q3_in       : combinational RAM read data for actions 0..3
//   out_valid/out_ready: output handshake
//   out_data           : Q value, or max Q on a policy beat
//   out_state          : state index of the beat
//   out_act            : action index, or greedy action on a policy beat
//   out_kind           : 0 = Q beat, 1 = policy beat
//   out_last           : final policy beat of the scan
module qtable_dump_reader
   import qlearn_pkg::*;
#(
   parameter int NUM_STATES = FINISH_STATE + 1,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     freeze,
   output logic                     done,
   output logic        [ADDR_W-1:0] rd_addr,
   input  logic signed [DATA_W-1:0] q0_in,
   input  logic signed [DATA_W-1:0] q1_in,
   input  logic signed [DATA_W-1:0] q2_in,
   input  logic signed [DATA_W-1:0] q3_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic        [ADDR_W-1:0] out_state,
   output logic        [1:0]        out_act,
   output logic                     out_kind,
   output logic                     out_last
);

   localparam logic [ADDR_W-1:0] LAST_STATE = ADDR_W'(NUM_STATES - 1);
   localparam logic [2:0]        POL_BEAT   = 3'(LAST_BEAT);

   dump_state_t              state;
   logic        [ADDR_W-1:0] state_cnt;
   logic        [2:0]        beat_idx;
   logic signed [DATA_W-1:0] snap [NUM_ACTIONS];
   logic signed [DATA_W-1:0] max_r;
   logic        [1:0]        idx_r;
   logic signed [DATA_W-1:0] max_c;
   logic        [1:0]        idx_c;
   logic                     handshake;

   // The argmax looks straight at the RAM read data so its result is ready
   // to be captured at the same edge as the snapshot at the end of LOAD.
   qmax4_argmax #(
      .DATA_W (DATA_W)
   ) u_argmax (
      .q0      (q0_in),
      .q1      (q1_in),
      .q2      (q2_in),
      .q3      (q3_in),
      .max_val (max_c),
      .max_idx (idx_c)
   );

   assign handshake = out_valid && out_ready;
   assign freeze    = busy;

   // Scan sequencer. rd_addr is loaded on the way into LOAD so the RAMs
   // present the row for the whole LOAD cycle; the row and its argmax are
   // captured at the end of LOAD and then replayed beat by beat. Every
   // out_* register only changes on a handshake, which keeps the beat
   // stable under backpressure. A start seen outside IDLE falls through.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         state_cnt <= '0;
         beat_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_state <= '0;
         out_act   <= '0;
         out_kind  <= KIND_Q;
         out_last  <= 1'b0;
         max_r     <= '0;
         idx_r     <= '0;
         for (int i = 0; i < NUM_ACTIONS; i++) begin
            snap[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_LOAD;
                  state_cnt <= '0;
                  rd_addr   <= '0;
                  busy      <= 1'b1;
               end
            end

            ST_LOAD: begin
               snap[0]   <= q0_in;
               snap[1]   <= q1_in;
               snap[2]   <= q2_in;
               snap[3]   <= q3_in;
               max_r     <= max_c;
               idx_r     <= idx_c;
               beat_idx  <= '0;
               out_valid <= 1'b1;
               out_data  <= q0_in;
               out_state <= state_cnt;
               out_act   <= 2'd0;
               out_kind  <= KIND_Q;
               out_last  <= 1'b0;
               state     <= ST_EMIT;
            end

            ST_EMIT: begin
               if (handshake) begin
                  if (beat_idx == POL_BEAT) begin
                     out_valid <= 1'b0;
                     out_kind  <= KIND_Q;
                     out_last  <= 1'b0;
                     if (state_cnt == LAST_STATE) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                     end else begin
                        state_cnt <= state_cnt + ADDR_W'(1);
                        rd_addr   <= state_cnt + ADDR_W'(1);
                        state     <= ST_LOAD;
                     end
                  end else if (beat_idx == POL_BEAT - 3'd1) begin
                     beat_idx <= POL_BEAT;
                     out_data <= max_r;
                     out_act  <= idx_r;
                     out_kind <= KIND_POLICY;
                     out_last <= (state_cnt == LAST_STATE);
                  end else begin
                     beat_idx <= beat_idx + 3'd1;
                     out_data <= snap[beat_idx[1:0] + 2'd1];
                     out_act  <= beat_idx[1:0] + 2'd1;
                  end
               end
            end

            ST_FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qtable_dump_reader.sv
// tb_qtable_dump_reader
// Scoreboard bench for qtable_dump_reader. A behavioural RAM model feeds
// the DUT; expected beats are queued when a scan is requested and a monitor
// pops and compares them on every accepted beat. A second instance with a
// single state covers the one-state boundary.
module tb_qtable_dump_reader;

   localparam int NS = 100;
   localparam int AW = 8;
   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 out_ready = 1'b0;
   logic                 busy, freeze, done;
   logic        [AW-1:0] rd_addr;
   logic signed [DW-1:0] q0_in, q1_in, q2_in, q3_in;
   logic                 out_valid;
   logic signed [DW-1:0] out_data;
   logic        [AW-1:0] out_state;
   logic        [1:0]    out_act;
   logic                 out_kind, out_last;

   logic                 start1 = 1'b0;
   logic                 busy1, freeze1, done1;
   logic        [AW-1:0] rd_addr1;
   logic signed [DW-1:0] p0_in, p1_in, p2_in, p3_in;
   logic                 out_valid1;
   logic signed [DW-1:0] out_data1;
   logic        [AW-1:0] out_state1;
   logic        [1:0]    out_act1;
   logic                 out_kind1, out_last1;

   logic signed [DW-1:0] ram0 [256];
   logic signed [DW-1:0] ram1 [256];
   logic signed [DW-1:0] ram2 [256];
   logic signed [DW-1:0] ram3 [256];

   typedef struct {
      longint data;
      int     st;
      int     act;
      int     kind;
      int     last;
   } beat_t;

   beat_t expQ[$];

   int testsRun    = 0;
   int testsFailed = 0;
   int beatCount   = 0;
   int lastCount   = 0;
   int lastBeatIdx = 0;
   int doneCount   = 0;
   int scanCycles  = 0;
   int cycleCnt    = 0;
   int loadCycle   = 0;
   bit busyPrev    = 1'b0;
   bit expectDone  = 1'b0;
   bit afterFin    = 1'b0;
   int oneBeats    = 0;
   int oneLastIdx  = 0;
   int oneDone     = 0;
   longint onePolData = -1;
   int onePolAct   = -1;

   always #5 clk = ~clk;

   assign q0_in = ram0[rd_addr];
   assign q1_in = ram1[rd_addr];
   assign q2_in = ram2[rd_addr];
   assign q3_in = ram3[rd_addr];
   assign p0_in = ram0[rd_addr1];
   assign p1_in = ram1[rd_addr1];
   assign p2_in = ram2[rd_addr1];
   assign p3_in = ram3[rd_addr1];

   qtable_dump_reader #(
      .NUM_STATES (NS),
      .ADDR_W     (AW),
      .DATA_W     (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .freeze    (freeze),
      .done      (done),
      .rd_addr   (rd_addr),
      .q0_in     (q0_in),
      .q1_in     (q1_in),
      .q2_in     (q2_in),
      .q3_in     (q3_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_state (out_state),
      .out_act   (out_act),
      .out_kind  (out_kind),
      .out_last  (out_last)
   );

   qtable_dump_reader #(
      .NUM_STATES (1),
      .ADDR_W     (AW),
      .DATA_W     (DW)
   ) u_one (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .busy      (busy1),
      .freeze    (freeze1),
      .done      (done1),
      .rd_addr   (rd_addr1),
      .q0_in     (p0_in),
      .q1_in     (p1_in),
      .q2_in     (p2_in),
      .q3_in     (p3_in),
      .out_valid (out_valid1),
      .out_ready (1'b1),
      .out_data  (out_data1),
      .out_state (out_state1),
      .out_act   (out_act1),
      .out_kind  (out_kind1),
      .out_last  (out_last1)
   );

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"},      longint'(busy), 0);
      checkOutput({tag, "_freeze"},    longint'(freeze), 0);
      checkOutput({tag, "_done"},      longint'(done), 0);
      checkOutput({tag, "_valid"},     longint'(out_valid), 0);
      checkOutput({tag, "_last"},      longint'(out_last), 0);
      checkOutput({tag, "_kind"},      longint'(out_kind), 0);
      checkOutput({tag, "_rd_addr"},   longint'(rd_addr), 0);
      checkOutput({tag, "_data"},      longint'(out_data), 0);
      checkOutput({tag, "_state"},     longint'(out_state), 0);
      checkOutput({tag, "_act"},       longint'(out_act), 0);
   endtask

   // Expected beat stream for one full scan, from the RAM contents.
   function automatic void pushScan();
      longint q[4];
      int     best;
      for (int s = 0; s < NS; s++) begin
         q[0] = ram0[s];
         q[1] = ram1[s];
         q[2] = ram2[s];
         q[3] = ram3[s];
         for (int a = 0; a < 4; a++) begin
            expQ.push_back('{q[a], s, a, 0, 0});
         end
         best = 0;
         for (int a = 1; a < 4; a++) begin
            if (q[a] > q[best]) best = a;
         end
         expQ.push_back('{q[best], s, best, 1, (s == NS - 1) ? 1 : 0});
      end
   endfunction

   task automatic applyStimulus(input bit expectScan);
      beatCount   = 0;
      lastCount   = 0;
      lastBeatIdx = 0;
      doneCount   = 0;
      scanCycles  = 0;
      if (expectScan) pushScan();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitBeats(input int n, input string tag);
      int guard = 0;
      while (beatCount < n && guard < 4000) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 4000) checkOutput({tag, "_timeout"}, beatCount, n);
   endtask

   task automatic waitScanEnd(input string tag);
      int guard = 0;
      while (!(expQ.size() == 0 && doneCount > 0 && !busy) && guard < 6000) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 6000) checkOutput({tag, "_timeout_queue"}, expQ.size(), 0);
   endtask

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Monitor: every accepted beat must be the next queued expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         beatCount++;
         if (out_last) begin
            lastCount++;
            lastBeatIdx = beatCount;
         end
         if (expQ.size() == 0) begin
            checkOutput("unexpected_beat_state", longint'(out_state), -1);
         end else begin
            beat_t e;
            e = expQ.pop_front();
            checkOutput("beat_data",  longint'(out_data), e.data);
            checkOutput("beat_state", longint'(out_state), e.st);
            checkOutput("beat_act",   longint'(out_act), e.act);
            checkOutput("beat_kind",  longint'(out_kind), e.kind);
            checkOutput("beat_last",  longint'(out_last), e.last);
            if (out_kind && out_state == 7) begin
               checkOutput("s7_pol_act",  longint'(out_act), 3);
               checkOutput("s7_pol_data", longint'(out_data), 10);
            end
            if (out_kind && out_state == 5) begin
               checkOutput("s5_tie_act",  longint'(out_act), 1);
               checkOutput("s5_tie_data", longint'(out_data), 50);
            end
            if (out_kind && out_state == 6) begin
               checkOutput("s6_neg_act",  longint'(out_act), 1);
               checkOutput("s6_neg_data", longint'(out_data), -3);
            end
         end
      end
   end

   // Done timing, freeze/busy equality, out_last qualification, scan length.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("freeze_eq_busy", longint'(freeze), longint'(busy));
         if (out_last) checkOutput("last_needs_valid", longint'(out_valid), 1);
         if (afterFin) begin
            checkOutput("busy_after_fin", longint'(busy), 0);
            afterFin = 1'b0;
         end
         if (expectDone) begin
            checkOutput("done_pulse",  longint'(done), 1);
            checkOutput("busy_in_fin", longint'(busy), 1);
            expectDone = 1'b0;
            afterFin   = 1'b1;
         end else if (done) begin
            checkOutput("unexpected_done", longint'(done), 0);
         end
         if (done) doneCount++;
         if (busy && !busyPrev) loadCycle = cycleCnt;
         if (out_valid && out_ready && out_last) begin
            expectDone = 1'b1;
            scanCycles = cycleCnt - loadCycle + 1;
         end
         busyPrev = busy;
      end else begin
         busyPrev   = 1'b0;
         expectDone = 1'b0;
         afterFin   = 1'b0;
      end
   end

   // Single-state instance observer (always ready).
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid1) begin
            oneBeats++;
            if (out_last1) oneLastIdx = oneBeats;
            if (out_kind1) begin
               onePolData = out_data1;
               onePolAct  = out_act1;
            end
         end
         if (done1) oneDone++;
      end
   end

   initial begin
      for (int s = 0; s < 256; s++) begin
         ram0[s] = DW'(s);
         ram1[s] = DW'(s + 1);
         ram2[s] = DW'(s + 2);
         ram3[s] = DW'(s + 3);
      end
      ram0[5] = -16'sd100; ram1[5] = 16'sd50; ram2[5] = 16'sd50; ram3[5] = 16'sd0;
      ram0[6] = -16'sd5;   ram1[6] = -16'sd3; ram2[6] = -16'sd3; ram3[6] = -16'sd32768;

      // Reset held with start high: nothing may move.
      rst       = 1'b1;
      start     = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         checkIdle("reset");
      end
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("idle_after_reset_busy",  longint'(busy), 0);
      checkOutput("idle_after_reset_valid", longint'(out_valid), 0);

      // Scan 1: full scan with a 3-cycle stall on state 12 beat 2.
      applyStimulus(1'b1);
      begin
         int  guard = 0;
         bit  found = 1'b0;
         while (!found && guard < 2000) begin
            @(posedge clk);
            #1;
            if (out_valid && out_state == 12 && out_act == 2 && !out_kind) found = 1'b1;
            guard++;
         end
         checkOutput("bp_found", longint'(found), 1);
         out_ready = 1'b0;
         repeat (3) begin
            @(negedge clk);
            checkOutput("bp_valid", longint'(out_valid), 1);
            checkOutput("bp_data",  longint'(out_data), 14);
            checkOutput("bp_state", longint'(out_state), 12);
            checkOutput("bp_act",   longint'(out_act), 2);
         end
         @(posedge clk);
         #1 out_ready = 1'b1;
         @(posedge clk);
         #1;
         checkOutput("bp_next_valid", longint'(out_valid), 1);
         checkOutput("bp_next_act",   longint'(out_act), 3);
         checkOutput("bp_next_data",  longint'(out_data), 15);
      end
      waitScanEnd("scan1");
      checkOutput("scan1_beats",    beatCount, 500);
      checkOutput("scan1_lastcnt",  lastCount, 1);
      checkOutput("scan1_lastidx",  lastBeatIdx, 500);
      checkOutput("scan1_done_cnt", doneCount, 1);
      checkOutput("scan1_cycles",   scanCycles, 603);
      repeat (3) @(negedge clk);
      checkOutput("scan1_freeze_low", longint'(freeze), 0);

      // Scan 2: ignored start at beat 37, reset at beat 40.
      applyStimulus(1'b1);
      waitBeats(37, "scan2_b37");
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      waitBeats(40, "scan2_b40");
      #1;
      rst       = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      expQ.delete();
      @(negedge clk);
      checkIdle("midrst");
      repeat (20) @(negedge clk);
      checkOutput("midrst_no_done", doneCount, 0);
      checkOutput("midrst_idle",    longint'(busy), 0);
      out_ready = 1'b1;

      // Scan 3: fresh scan after reset starts from state 0.
      applyStimulus(1'b1);
      begin
         int guard = 0;
         @(negedge clk);
         while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         checkOutput("rescan_first_valid", longint'(out_valid), 1);
         checkOutput("rescan_first_state", longint'(out_state), 0);
         checkOutput("rescan_first_act",   longint'(out_act), 0);
      end
      waitScanEnd("scan3");
      checkOutput("scan3_beats",    beatCount, 500);
      checkOutput("scan3_lastidx",  lastBeatIdx, 500);
      checkOutput("scan3_done_cnt", doneCount, 1);
      checkOutput("scan3_cycles",   scanCycles, 600);

      // Single-state table: exactly five beats, out_last on the fifth.
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("one_beats",    oneBeats, 5);
      checkOutput("one_lastidx",  oneLastIdx, 5);
      checkOutput("one_done",     oneDone, 1);
      checkOutput("one_pol_act",  onePolAct, 3);
      checkOutput("one_pol_data", onePolData, 3);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
